spi_slave_rx: RTL and testbench

- Mode-0 SPI slave byte receiver; sits directly upstream of the SPI-byte-to-FND assembly FSM.
- Feeds that FSM with `data[7:0]`, `CS` and a one-cycle `done` pulse per received byte.
- Oversamples the external `SCLK`/`MOSI`/`SS` pins in the system clock domain.
- Shifts in bits on `SCLK` rising edges and supports multi-byte frames within one `SS` low period.

---
 rtl/spi_slave_rx.sv | 138 +++++++++++++
 tb/tb_spi_slave_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - Mode-0 SPI slave byte receiver, oversampled in the clk domain.
// Optional MISO return path is built when SPI_SLAVE_TX_EN is defined.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       SS,
  output logic       MISO,
  input  logic [7:0] tx_data,
  output logic [7:0] data,
  output logic       done,
  output logic       CS
);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] sclk_ff, mosi_ff, ss_ff;
  logic       sclk_prev;
  logic       sclk_s, mosi_s, ss_s;
  logic       rise;
  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] shift, shift_nx;
  logic [7:0] data_nx;
  logic       done_nx;

  assign sclk_s = sclk_ff[SYNC_STAGES-1];
  assign mosi_s = mosi_ff[SYNC_STAGES-1];
  assign ss_s   = ss_ff[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_ff   <= '0;
      mosi_ff   <= '0;
      ss_ff     <= '1;
      sclk_prev <= 1'b0;
      state     <= IDLE;
      cnt       <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      done      <= 1'b0;
      CS        <= 1'b1;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], SCLK};
      mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], MOSI};
      ss_ff     <= {ss_ff[SYNC_STAGES-2:0], SS};
      sclk_prev <= sclk_s;
      state     <= state_nx;
      cnt       <= cnt_nx;
      shift     <= shift_nx;
      data      <= data_nx;
      done      <= done_nx;
      CS        <= (state_nx != RECV);
    end
  end

  // A rising SCLK wins over SS release so a byte finishing together with SS still completes.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift_nx = shift;
    data_nx  = data;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx   = 3'd0;
        shift_nx = 8'h00;
        if (!ss_s) state_nx = RECV;
      end
      RECV: begin
        if (rise) begin
          shift_nx = MSB_FIRST ? {shift[6:0], mosi_s} : {mosi_s, shift[7:1]};
          cnt_nx   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            data_nx = shift_nx;
            done_nx = 1'b1;
          end
        end else if (ss_s) begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
          shift_nx = 8'h00;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_TX_EN
  logic       fall;
  logic [7:0] tx_sr, tx_sr_nx;
  logic       tx_hold, tx_hold_nx;
  logic       miso_nx;

  assign fall = ~sclk_s & sclk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr   <= 8'h00;
      tx_hold <= 1'b0;
      MISO    <= 1'b0;
    end else begin
      tx_sr   <= tx_sr_nx;
      tx_hold <= tx_hold_nx;
      MISO    <= miso_nx;
    end
  end

  // A reload at byte completion lands before that byte's last falling edge; tx_hold
  // swallows that fall so the new first bit stays on MISO for the master's next rise.
  always_comb begin
    tx_sr_nx   = tx_sr;
    tx_hold_nx = tx_hold;
    if (state == IDLE && state_nx == RECV) begin
      tx_sr_nx   = tx_data;
      tx_hold_nx = 1'b0;
    end else if (state == RECV) begin
      if (done_nx) begin
        tx_sr_nx   = tx_data;
        tx_hold_nx = 1'b1;
      end else if (fall) begin
        if (tx_hold) tx_hold_nx = 1'b0;
        else tx_sr_nx = MSB_FIRST ? {tx_sr[6:0], 1'b0} : {1'b0, tx_sr[7:1]};
      end
    end
    miso_nx = (state_nx == RECV) ? (MSB_FIRST ? tx_sr_nx[7] : tx_sr_nx[0]) : 1'b0;
  end
`else
  logic unused_tx;
  assign unused_tx = ^tx_data;
  assign MISO      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - Scoreboard bench for spi_slave_rx, MSB-first and LSB-first instances.
// Builds the MISO read-back checks when SPI_SLAVE_TX_EN is defined.
module tb_spi_slave_rx;
  localparam int SS_N = 2;
  localparam int HALF = 8;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, ss = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic miso_m, miso_l, done_m, done_l, cs_m, cs_l;
  logic [7:0] data_m, data_l;

  always #5 clk = ~clk;

  spi_slave_rx #(.SYNC_STAGES(SS_N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .SCLK(sclk), .MOSI(mosi), .SS(ss), .MISO(miso_m),
    .tx_data(tx_data), .data(data_m), .done(done_m), .CS(cs_m));

  spi_slave_rx #(.SYNC_STAGES(SS_N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .SCLK(sclk), .MOSI(mosi), .SS(ss), .MISO(miso_l),
    .tx_data(tx_data), .data(data_l), .done(done_l), .CS(cs_l));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  exp_t qm[$];
  exp_t ql[$];
  logic [7:0] last_m = 8'h00, last_l = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always @(negedge clk) begin : mon_m
    exp_t e;
    if (!rst && done_m) begin
      if (qm.size() == 0) chk("m_unexpected_done", 1, 0);
      else begin
        e = qm.pop_front();
        chk("m_data", data_m, e.b);
        chk("m_latency", cyc - e.t, SS_N + 1);
        chk("m_cs_at_done", cs_m, 0);
      end
    end
  end

  always @(negedge clk) begin : mon_l
    exp_t e;
    if (!rst && done_l) begin
      if (ql.size() == 0) chk("l_unexpected_done", 1, 0);
      else begin
        e = ql.pop_front();
        chk("l_data", data_l, e.b);
        chk("l_latency", cyc - e.t, SS_N + 1);
        chk("l_cs_at_done", cs_l, 0);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master side: drive MOSI msb-first, sample MISO on each SCLK rise.
  task automatic send_byte(input logic [7:0] b, input int nbits, input bit ss_on_last);
    logic [7:0] rm, rl;
    rm = 8'h00;
    rl = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      wait_clk(HALF);
      if (i == 7) begin
        qm.push_back('{b, cyc});
        ql.push_back('{rev(b), cyc});
        last_m = b;
        last_l = rev(b);
      end
      sclk = 1'b1;
      if (i == 7 && ss_on_last) ss = 1'b1;
      rm = {rm[6:0], miso_m};
      rl = {miso_l, rl[7:1]};
`ifndef SPI_SLAVE_TX_EN
      chk("m_miso_zero", miso_m, 0);
      chk("l_miso_zero", miso_l, 0);
`endif
      wait_clk(HALF);
      sclk = 1'b0;
    end
`ifdef SPI_SLAVE_TX_EN
    if (nbits == 8) begin
      chk("m_miso_byte", rm, tx_data);
      chk("l_miso_byte", rl, tx_data);
    end
`endif
  endtask

  task automatic frame_start();
    ss = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    int k;
    wait_clk(HALF);
    ss = 1'b1;
    k = 0;
    while ((cs_m !== 1'b1 || cs_l !== 1'b1) && k < SS_N + 1) begin
      wait_clk(1);
      k++;
    end
    chk("m_cs_release", cs_m, 1);
    chk("l_cs_release", cs_l, 1);
    chk("m_data_hold", data_m, last_m);
    chk("l_data_hold", data_l, last_l);
    wait_clk(HALF);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_data"}, data_m, 8'h00);
    chk({tag, "_l_data"}, data_l, 8'h00);
    chk({tag, "_m_done"}, done_m, 0);
    chk({tag, "_l_done"}, done_l, 0);
    chk({tag, "_m_cs"}, cs_m, 1);
    chk({tag, "_l_cs"}, cs_l, 1);
    chk({tag, "_m_miso"}, miso_m, 0);
    chk({tag, "_l_miso"}, miso_l, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with random pin activity
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sclk = 1'($urandom);
      mosi = 1'($urandom);
      ss = 1'($urandom);
      tx_data = 8'($urandom);
      wait_clk(1);
      chk_reset_vals("rst");
    end
    sclk = 1'b0;
    ss = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    // SS high: SCLK activity must be ignored
    for (int i = 0; i < 8; i++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      wait_clk(4);
      chk("idle_m_cs", cs_m, 1);
      chk("idle_l_cs", cs_l, 1);
      chk("idle_m_data", data_m, 8'h00);
    end
    sclk = 1'b0;
    wait_clk(4);

    tx_data = 8'h5A;
    frame_start();
    send_byte(8'hA5, 8, 1'b0);
    frame_end();

    tx_data = 8'hC7;
    frame_start();
    send_byte(8'h34, 8, 1'b0);
    send_byte(8'h12, 8, 1'b0);
    frame_end();

    // Abort after 5 bits: data must keep 8'h12
    frame_start();
    send_byte(8'hFF, 5, 1'b0);
    frame_end();

    frame_start();
    send_byte(8'h0F, 8, 1'b0);
    frame_end();

    // Asynchronous reset mid-byte
    frame_start();
    send_byte(8'h99, 3, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    sclk = 1'b0;
    ss = 1'b1;
    last_m = 8'h00;
    last_l = 8'h00;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);

    tx_data = 8'h3C;
    frame_start();
    send_byte(8'hC3, 8, 1'b0);
    frame_end();

    // SS release coinciding with the 8th rise
    frame_start();
    send_byte(8'h96, 8, 1'b1);
    wait_clk(HALF);
    chk("sim_m_cs", cs_m, 1);
    chk("sim_l_cs", cs_l, 1);
    chk("sim_m_data", data_m, 8'h96);
    chk("sim_l_data", data_l, rev(8'h96));

    for (int f = 0; f < 6; f++) begin
      tx_data = 8'($urandom);
      n = $urandom_range(1, 3);
      frame_start();
      for (int j = 0; j < n; j++) send_byte(8'($urandom), 8, 1'b0);
      frame_end();
    end

    wait_clk(10);
    chk("m_queue_empty", qm.size(), 0);
    chk("l_queue_empty", ql.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
